// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with terminal-count strobe.
// Supports one-shot or periodic auto-reload, pause/resume and restart.
// Optional prescaler compiled in with macro COUNTDOWN_PRESCALE_EN.
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   rst      in   synchronous active-high reset
//   ld       in   load reload register (and count outside RUN) from v
//   v        in   WIDTH-bit load value
//   start    in   start / resume / restart request
//   stop     in   pause request
//   periodic in   1 = auto-reload on expiry, 0 = one-shot
//   count    out  current count (registered)
//   busy     out  high while running (registered)
//   tc       out  one-cycle terminal-count strobe (registered)
module countdown_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE must be >= 1");
  end

  state_t           state, state_d;
  logic [WIDTH-1:0] reload, reload_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] eff_count, eff_reload;
  logic             tc_d, busy_d;
  logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;

  assign tick = (pre == PW'(PRESCALE - 1));

  // Prescaler runs only in RUN; restart and stop discard any partial interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (state != RUN || start || stop || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      reload <= reload_d;
      tc     <= tc_d;
      busy   <= busy_d;
    end
  end

  // Next-state logic; a same-cycle ld makes v the effective count/reload value
  always_comb begin
    state_d    = state;
    count_d    = count;
    reload_d   = reload;
    tc_d       = 1'b0;
    eff_count  = ld ? v : count;
    eff_reload = ld ? v : reload;
    unique case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          if (ld) begin
            reload_d = v;
            count_d  = v;
            state_d  = IDLE;
          end
          if (start) begin
            if (eff_count != '0) begin
              count_d = eff_count;
              state_d = RUN;
            end else if (eff_reload != '0) begin
              count_d = eff_reload;
              state_d = RUN;
            end else begin
              count_d = '0;
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          if (ld) begin
            reload_d = v;
          end
          if (start) begin
            if (eff_reload != '0) begin
              count_d = eff_reload;
            end else begin
              count_d = '0;
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end else if (tick) begin
            if (count > WIDTH'(1)) begin
              count_d = count - WIDTH'(1);
            end else begin
              // Expiry: count is 1 here, never 0, so no underflow
              tc_d = 1'b1;
              if (periodic && eff_reload != '0) begin
                count_d = eff_reload;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default build, no prescaler).
module tb_countdown_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] v;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  int checks   = 0;
  int failures = 0;

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .v        (v),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .count    (count),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int c, input int b, input int t);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".busy"}, 32'(busy), b);
    check({tag, ".tc"}, 32'(tc), t);
  endtask

  initial begin
    int first_tc;
    int exp_c;

    rst = 1'b1; ld = 1'b1; v = 8'h55; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    tick(); tick();
    check_out("reset", 0, 0, 0);
    rst = 1'b0; ld = 1'b0;
    tick(); tick();
    check_out("idle_after_reset", 0, 0, 0);

    // One-shot from 5
    ld = 1'b1; v = 8'd5;
    tick();
    check_out("os_load", 5, 0, 0);
    ld = 1'b0; start = 1'b1;
    tick();
    check_out("os_start", 5, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_out($sformatf("os_dec%0d", k), 5 - k, 1, 0);
    end
    tick();
    check_out("os_expire", 0, 0, 1);
    tick();
    check_out("os_done_hold", 0, 0, 0);

    // Periodic from 3
    ld = 1'b1; v = 8'd3;
    tick();
    check_out("per_load", 3, 0, 0);
    ld = 1'b0; start = 1'b1; periodic = 1'b1;
    tick();
    check_out("per_start", 3, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_c = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 1 : 3);
      tick();
      check_out($sformatf("per_cyc%0d", k), exp_c, 1, (exp_c == 3) ? 1 : 0);
    end
    tick();
    check_out("per_mid2", 2, 1, 0);
    periodic = 1'b0;
    tick();
    check_out("per_mid1", 1, 1, 0);
    tick();
    check_out("per_drop_expire", 0, 0, 1);

    // Pause / resume / stop beats start
    ld = 1'b1; v = 8'd10;
    tick();
    ld = 1'b0; start = 1'b1;
    tick();
    check_out("pr_start", 10, 1, 0);
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check_out("pr_4ticks", 6, 1, 0);
    stop = 1'b1;
    tick();
    check_out("pr_pause", 6, 0, 0);
    stop = 1'b0; start = 1'b1;
    tick();
    check_out("pr_resume", 6, 1, 0);
    start = 1'b0;
    tick(); tick();
    check_out("pr_run", 4, 1, 0);
    stop = 1'b1; start = 1'b1;
    tick();
    check_out("pr_stop_wins", 4, 0, 0);
    stop = 1'b0;

    // Resume then restart mid-run reloads full value
    tick();
    check_out("rs_resume", 4, 1, 0);
    start = 1'b0;
    tick();
    check_out("rs_dec", 3, 1, 0);
    start = 1'b1;
    tick();
    check_out("rs_restart", 10, 1, 0);
    start = 1'b0;

    // ld in RUN only changes the reload value
    ld = 1'b1; v = 8'd2;
    tick();
    check_out("ldrun_unaffected", 9, 1, 0);
    ld = 1'b0; periodic = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check_out("ldrun_at1", 1, 1, 0);
    tick();
    check_out("ldrun_reload2", 2, 1, 1);
    tick();
    check_out("ldrun_dec", 1, 1, 0);
    tick();
    check_out("ldrun_reload2b", 2, 1, 1);
    periodic = 1'b0; stop = 1'b1;
    tick();
    check_out("ldrun_stop", 2, 0, 0);
    stop = 1'b0;

    // ld 0 + start in IDLE: immediate DONE with one tc
    ld = 1'b1; v = 8'd0; start = 1'b1;
    tick();
    check_out("zero_start", 0, 0, 1);
    ld = 1'b0; start = 1'b0;
    tick();
    check_out("zero_after", 0, 0, 0);

    // Restart to 0 while running
    ld = 1'b1; v = 8'd3;
    tick();
    ld = 1'b0; start = 1'b1;
    tick();
    check_out("rz_run", 3, 1, 0);
    ld = 1'b1; v = 8'd0;
    tick();
    check_out("rz_restart0", 0, 0, 1);
    ld = 1'b0; start = 1'b0;

    // Max value: expiry after exactly 255 ticks
    ld = 1'b1; v = 8'hFF;
    tick();
    ld = 1'b0; start = 1'b1;
    tick();
    check_out("max_start", 255, 1, 0);
    start = 1'b0;
    first_tc = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (tc && first_tc == 0) first_tc = k;
      if (first_tc != 0) break;
    end
    check("max_ticks", 32'(first_tc), 255);
    check_out("max_done", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting timer; the decrementing counterpart to the team's loadable up-counter.
- Loads a WIDTH-bit start value and counts down while running.
- Pulses a terminal-count strobe when the count expires.
- Supports one-shot or periodic auto-reload, pause/resume, and restart. Used as the timeout and periodic-tick source beside the up-counter in the lab top level.

Parameters:
WIDTH, 8, width of load value, reload register and count
PRESCALE, 4, clock cycles per decrement tick when the optional prescaler is compiled in (must be >= 1)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; synchronous and active-high
ld  input  1  load: reload register <= v; count <= v except in RUN
v  input  WIDTH  value to load
start  input  1  start / resume / restart request
stop  input  1  pause request
periodic  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled at each expiry
count  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN
tc  output  1  terminal-count strobe, exactly one cycle wide per expiry

Behaviour:
- Reset (rst=1 at posedge) overrides all inputs: state=IDLE, count=0, reload=0, tc=0, busy=0.
- All outputs are registered. busy = (state==RUN). tc defaults to 0 every cycle unless set below.
- Priority within a cycle: rst > stop > ld > start.
- IDLE:
  - ld: reload<=v, count<=v.
  - start: if the effective count (v when ld is also high, else count) is nonzero -> RUN, count unchanged (resume).
  - start with effective count==0: count<=reload value (v if ld), then RUN. If that value is 0 -> DONE with tc=1 instead.
  - stop: no effect.
- RUN, on each tick (every cycle without the prescaler):
  - count>1: count<=count-1.
  - count==1, periodic=0: count<=0, tc<=1, state->DONE.
  - count==1, periodic=1, reload!=0: count<=reload, tc<=1, stay RUN. Period = reload ticks; count never shows 0.
  - count==1, periodic=1, reload==0: count<=0, tc<=1, ->DONE.
- RUN, other inputs:
  - stop: ->IDLE, count held, no tc.
  - ld: reload<=v only; count unaffected; new value used at next reload/restart.
  - start without stop: restart, count<=reload (v if ld same cycle), stay RUN. Restart to 0 -> DONE with tc=1.
- DONE: count holds 0.
  - ld: reload<=v, count<=v, ->IDLE.
  - start: behaves as IDLE start from count==0.
  - stop: ->IDLE.
- Arithmetic is modulo 2^WIDTH. The decrement never underflows because count==0 is never decremented in RUN.
- Max load all-ones gives 2^WIDTH-1 ticks to expiry.

Optional Feature:
- Macro COUNTDOWN_PRESCALE_EN.
- Defined: an internal prescaler counter produces a tick every PRESCALE cycles while in RUN. The prescaler clears on rst, on any entry into RUN (start/restart), and on stop. A restart also discards the partial prescale. Expiry in one-shot therefore occurs count*PRESCALE cycles after start.
- Undefined: no prescaler logic; tick=1 on every RUN cycle. PRESCALE is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with ld=1, v=8'h55 -> count=0, busy=0, tc=0. After release with no inputs, count stays 0.
- One-shot: ld v=5, then start pulse, periodic=0 -> count 5,4,3,2,1,0 on successive cycles. tc=1 only in the cycle count becomes 0; busy drops the same cycle; state holds DONE with count=0.
- Periodic: ld v=3, start, periodic=1 for 10 cycles -> count 3,2,1,3,2,1,... tc high once every 3 cycles, busy stays 1. Drop periodic mid-period -> next expiry goes to 0 and DONE.
- Pause/resume and priority: ld v=10, start, stop after 4 ticks -> count=6, busy=0. Start -> resumes 6,5,... Assert stop and start together in RUN -> stop wins, IDLE.
- Boundaries: ld v=0 + start same cycle -> DONE with one tc pulse. v=8'hFF one-shot -> tc after exactly 255 ticks. ld v=2 during RUN -> current countdown unaffected; next periodic reload = 2.
- With COUNTDOWN_PRESCALE_EN, PRESCALE=4: ld v=2, start -> count decrements every 4 cycles; tc arrives 8 cycles after start. A restart mid-prescale restarts the full 4-cycle interval.
